audio_sample_fetch: RTL and testbench

Avalon-MM read master plus a small sample FIFO that streams stereo PCM frames out of the 32-bit single-port on-chip sample memory (8192 words, 1-cycle fixed read latency, no waitrequest) toward the audio DAC serializer. Firmware on the Nios II programs a base address and a word count and starts playback. The block then issues reads at up to one word per clock, splits each word into left/right 16-bit samples, and presents them on a valid/ready stream. It supports one-shot and looped playback.

---
 rtl/audio_sample_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_audio_sample_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_fetch.sv
// audio_sample_fetch
//   Avalon-MM read master that streams stereo PCM words out of the on-chip
//   sample memory into a small first-word-fall-through FIFO feeding the DAC
//   serializer. Each 32-bit word is split into a left [31:16] and a right
//   [15:0] sample. It supports one-shot and looped playback.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   start, stop, loop     control; start/stop are one-cycle pulses, loop is
//                         sampled at start
//   base_addr, length     first word and word count, latched at start
//   mem_address, mem_chipselect, mem_write, mem_readdata
//                         read master toward the sample memory (1-cycle latency)
//   sample_valid, sample_ready, sample_left, sample_right
//                         valid/ready sample stream (FIFO head)
//   busy                  high while fetching or draining
//   done                  one-cycle pulse on normal completion
module audio_sample_fetch #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  input  logic [31:0]       mem_readdata,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [15:0]       sample_left,
  output logic [15:0]       sample_right,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;  // holds fifo_count + inflight (up to DEPTH+2)

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e                           state_q, state_d;
  logic [ADDR_W-1:0]                base_q, base_d;
  logic [ADDR_W-1:0]                len_q, len_d;
  logic                             loop_q, loop_d;
  logic [ADDR_W-1:0]                off_q, off_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic                             cs_q, cs_d;
  logic                             rd_pend_q, rd_pend_d;  // read issued last cycle
  logic                             done_q, done_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [PW:0]                      count_q, count_d;
  logic [FIFO_DEPTH-1:0][31:0]      fifo_q, fifo_d;

  logic                             push, pop, credit;
  logic [CW-1:0]                    occ;
  logic                             f_active, f_loop;
  logic [ADDR_W-1:0]                f_base, f_len, f_off, off_nxt;

  // ------------------------------------------------------------------
  // Stream side
  // ------------------------------------------------------------------
  assign sample_valid = (count_q != '0);
  assign pop          = sample_valid && sample_ready;
  // Data for the read issued last cycle is on mem_readdata now.
  assign push         = rd_pend_q;

  assign sample_left  = sample_valid ? fifo_q[rd_ptr_q][31:16] : 16'h0000;
  assign sample_right = sample_valid ? fifo_q[rd_ptr_q][15:0]  : 16'h0000;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_readdata;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (stop) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // ------------------------------------------------------------------
  // Issue credit: the chipselect is registered, so the decision made now
  // is for next cycle. Everything stored or in flight, minus what leaves
  // this cycle, must stay below the FIFO depth for a new read to fit.
  // ------------------------------------------------------------------
  assign occ    = CW'(count_q) + CW'(cs_q) + CW'(rd_pend_q) - CW'(pop);
  assign credit = (occ < CW'(FIFO_DEPTH));

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    loop_d    = loop_q;
    off_d     = off_q;
    addr_d    = addr_q;
    cs_d      = 1'b0;
    rd_pend_d = cs_q;
    done_d    = 1'b0;
    f_active  = 1'b0;
    f_base    = base_q;
    f_len     = len_q;
    f_loop    = loop_q;
    f_off     = off_q;
    off_nxt   = '0;

    case (state_q)
      S_IDLE: begin
        // The first read is decided in the start cycle straight from the
        // inputs so that chipselect rises the very next cycle.
        if (start && (length != '0)) begin
          f_active = 1'b1;
          f_base   = base_addr;
          f_len    = length;
          f_loop   = loop;
          f_off    = '0;
          base_d   = base_addr;
          len_d    = length;
          loop_d   = loop;
          off_d    = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: f_active = 1'b1;
      S_DRAIN: begin
        if (!cs_q && !rd_pend_q && (count_d == '0)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (f_active && credit) begin
      cs_d    = 1'b1;
      addr_d  = f_base + f_off;  // wraps modulo 2^ADDR_W
      off_nxt = f_off + ADDR_W'(1);
      if (off_nxt == f_len) begin
        off_d = '0;
        if (!f_loop) state_d = S_DRAIN;
      end else begin
        off_d = off_nxt;
      end
    end

    // Abort wins over everything, including a simultaneous start; the read
    // issued this cycle is dropped by clearing its capture flag.
    if (stop) begin
      state_d   = S_IDLE;
      cs_d      = 1'b0;
      rd_pend_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      off_q     <= '0;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fifo_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      rd_pend_q <= rd_pend_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fifo_q    <= fifo_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = 1'b0;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_audio_sample_fetch.sv
// Directed bench for audio_sample_fetch with a 1-cycle-latency memory model.
module tb_audio_sample_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, loop;
  logic [12:0] base_addr, length;
  logic [12:0] mem_address;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_readdata;
  logic        sample_valid, sample_ready;
  logic [15:0] sample_left, sample_right;
  logic        busy, done;

  logic [31:0] smem [0:8191];

  int n_cmp = 0;
  int n_bad = 0;

  audio_sample_fetch #(.ADDR_W(13), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .base_addr(base_addr), .length(length),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_readdata(mem_readdata),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_left(sample_left), .sample_right(sample_right),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_chipselect) mem_readdata <= smem[mem_address];

  function automatic logic [31:0] exp_word(input logic [12:0] a);
    return {~{3'b000, a}, {3'b000, a}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [12:0] b, input logic [12:0] l, input logic lp);
    base_addr = b;
    length    = l;
    loop      = lp;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  // Pops with ready high until done; checks order, count and the done pulse.
  task automatic drain_check(input string tag, input logic [12:0] b, input int n);
    int got  = 0;
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (sample_valid) begin
        chk(tag, {sample_left, sample_right}, exp_word(b + 13'(got)));
        got++;
      end
      if (done) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_done"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [12:0] seq [3];
    int ncs;

    for (int i = 0; i < 8192; i++) smem[i] = exp_word(13'(i));
    for (int i = 0; i < 4; i++) smem[16 + i] = 32'hAAAA0001 + 32'(i);
    mem_readdata = '0;
    reset_n = 1'b0; start = 0; stop = 0; loop = 0; sample_ready = 0;
    base_addr = '0; length = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_addr", {19'b0, mem_address}, 32'h0);
    chk("rst_cs", {31'b0, mem_chipselect}, 32'h0);
    chk("rst_wr", {31'b0, mem_write}, 32'h0);
    chk("rst_valid", {31'b0, sample_valid}, 32'h0);
    chk("rst_lr", {sample_left, sample_right}, 32'h0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
    reset_n = 1'b1;
    cyc();

    // One-shot, ready high: cs cycles 1-4, valid 3-6, done 7
    sample_ready = 1'b1;
    base_addr = 13'h0010; length = 13'd4; loop = 1'b0; start = 1'b1;
    chk("t1_busy_c0", {31'b0, busy}, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      start = 1'b0;
      chk("t1_cs", {31'b0, mem_chipselect}, {31'b0, (c >= 1 && c <= 4)});
      if (c >= 1 && c <= 4) chk("t1_addr", {19'b0, mem_address}, 32'h10 + 32'(c - 1));
      chk("t1_valid", {31'b0, sample_valid}, {31'b0, (c >= 3 && c <= 6)});
      if (c >= 3 && c <= 6) chk("t1_data", {sample_left, sample_right}, 32'hAAAA0000 + 32'(c - 2));
      chk("t1_done", {31'b0, done}, {31'b0, (c == 7)});
      chk("t1_busy", {31'b0, busy}, {31'b0, (c >= 1 && c <= 6)});
    end

    // Backpressure: exactly 8 reads with ready low, then full ordered delivery
    sample_ready = 1'b0;
    do_start(13'h0100, 13'd20, 1'b0);
    ncs = 0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_chipselect) ncs++;
      cyc();
    end
    chk("t2_issued", ncs, 32'd8);
    chk("t2_valid", {31'b0, sample_valid}, 32'h1);
    chk("t2_head", {sample_left, sample_right}, exp_word(13'h0100));
    sample_ready = 1'b1;
    drain_check("t2_data", 13'h0100, 20);
    cyc();
    chk("t2_busy_after", {31'b0, busy}, 32'h0);

    // Wrap and gapless loop
    seq[0] = 13'h1FFE; seq[1] = 13'h1FFF; seq[2] = 13'h0000;
    do_start(13'h1FFE, 13'd3, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      chk("t3_cs", {31'b0, mem_chipselect}, 32'h1);
      chk("t3_addr", {19'b0, mem_address}, {19'b0, seq[(c - 1) % 3]});
      chk("t3_done", {31'b0, done}, 32'h0);
      if (c >= 3) chk("t3_data", {sample_left, sample_right}, exp_word(seq[(c - 3) % 3]));
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t3_stop_busy", {31'b0, busy}, 32'h0);
    chk("t3_stop_valid", {31'b0, sample_valid}, 32'h0);
    chk("t3_stop_done", {31'b0, done}, 32'h0);

    // Stop with 2 in flight and FIFO half full, then a clean replay
    sample_ready = 1'b0;
    do_start(13'h0200, 13'd20, 1'b0);
    for (int c = 1; c < 6; c++) cyc();
    chk("t4_pre_cs", {31'b0, mem_chipselect}, 32'h1);
    chk("t4_pre_head", {sample_left, sample_right}, exp_word(13'h0200));
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t4_busy", {31'b0, busy}, 32'h0);
    chk("t4_valid", {31'b0, sample_valid}, 32'h0);
    chk("t4_done", {31'b0, done}, 32'h0);
    cyc();
    chk("t4_valid2", {31'b0, sample_valid}, 32'h0);
    chk("t4_done2", {31'b0, done}, 32'h0);
    chk("t4_cs2", {31'b0, mem_chipselect}, 32'h0);
    sample_ready = 1'b1;
    do_start(13'h0300, 13'd2, 1'b0);
    drain_check("t4_replay", 13'h0300, 2);
    cyc();

    // start with length 0 is ignored
    do_start(13'h0040, 13'd0, 1'b0);
    chk("t5_len0_busy", {31'b0, busy}, 32'h0);
    chk("t5_len0_cs", {31'b0, mem_chipselect}, 32'h0);
    cyc();
    chk("t5_len0_busy2", {31'b0, busy}, 32'h0);

    // stop and start together from idle: stop wins
    base_addr = 13'h0600; length = 13'd4; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("t5_ss_busy", {31'b0, busy}, 32'h0);
    chk("t5_ss_cs", {31'b0, mem_chipselect}, 32'h0);

    // start while busy keeps the latched parameters
    do_start(13'h0400, 13'd3, 1'b0);
    base_addr = 13'h0500; length = 13'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    drain_check("t5_rebusy", 13'h0400, 3);
    cyc();

    // Asynchronous reset in the middle of a fetch
    do_start(13'h0700, 13'd100, 1'b0);
    cyc(); cyc(); cyc();
    chk("t6_pre_busy", {31'b0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_addr", {19'b0, mem_address}, 32'h0);
    chk("t6_cs_busy_done", {29'b0, mem_chipselect, busy, done}, 32'h0);
    chk("t6_valid", {31'b0, sample_valid}, 32'h0);
    chk("t6_lr", {sample_left, sample_right}, 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("t6_post_busy", {31'b0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
